// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - request FIFO and one-at-a-time issue sequencer for a shared fixed-point divider
module div_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TAG_W   = 9,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDTH-1:0]        req_a,
    input  logic [WIDTH-1:0]        req_b,
    input  logic [TAG_W-1:0]        req_tag,

    output logic                    div_start,
    output logic [WIDTH-1:0]        div_a,
    output logic [WIDTH-1:0]        div_b,
    input  logic                    div_done,
    input  logic                    div_valid,
    input  logic                    div_dbz,
    input  logic                    div_ovf,
    input  logic [WIDTH-1:0]        div_val,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_val,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [1:0]              rsp_err,

    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // FIFO storage and pointers (one extra bit distinguishes full from empty)
    logic [WIDTH-1:0] fifo_a_q   [DEPTH];
    logic [WIDTH-1:0] fifo_b_q   [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             push;
    logic             pop;

    // Sequencer state
    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Registered outputs
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_val_q, rsp_val_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [1:0]       rsp_err_q, rsp_err_d;

    assign occ       = wr_ptr_q - rd_ptr_q;
    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign req_ready = (occ != FULL_CNT);
    assign count     = occ;

    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

    // Push on handshake, pop exactly once per issued division
    always_comb begin
        push     = req_valid && req_ready;
        pop      = (state_q == S_ISSUE);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Request payload storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_a_q[wr_idx]   <= req_a;
            fifo_b_q[wr_idx]   <= req_b;
            fifo_tag_q[wr_idx] <= req_tag;
        end
    end

    // Issue / wait / hold sequencing with timeout fallback
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        tag_d       = tag_q;
        div_start_d = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_val_d   = rsp_val_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (occ != '0) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                div_a_d     = fifo_a_q[rd_idx];
                div_b_d     = fifo_b_q[rd_idx];
                tag_d       = fifo_tag_q[rd_idx];
                div_start_d = 1'b1;
                tmo_d       = '0;
                state_d     = S_WAIT;
            end

            S_WAIT: begin
                if (div_done) begin
                    rsp_err_d   = {div_ovf, div_dbz};
                    rsp_val_d   = (div_valid && !div_ovf && !div_dbz) ? div_val : '0;
                    rsp_tag_d   = tag_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    // Divider never answered: report a synthetic error so the
                    // consumer still gets exactly one response per request.
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_val_d   = '0;
                    rsp_tag_d   = tag_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = (occ != '0) ? S_ISSUE : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards queued and in-flight work
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            tag_q       <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_val_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            tag_q       <= tag_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_val_q   <= rsp_val_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;

    localparam int WIDTH   = 16;
    localparam int TAG_W   = 9;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int FBITS   = 8;
    localparam int NRAND   = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n     = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [15:0]      req_a     = '0;
    logic [15:0]      req_b     = '0;
    logic [8:0]       req_tag   = '0;
    logic             div_start;
    logic [15:0]      div_a;
    logic [15:0]      div_b;
    logic             div_done  = 1'b0;
    logic             div_valid = 1'b0;
    logic             div_dbz   = 1'b0;
    logic             div_ovf   = 1'b0;
    logic [15:0]      div_val   = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [15:0]      rsp_val;
    logic [8:0]       rsp_tag;
    logic [1:0]       rsp_err;
    logic [2:0]       count;

    div_sequencer #(
        .WIDTH  (WIDTH),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_tag  (req_tag),
        .div_start(div_start),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_done (div_done),
        .div_valid(div_valid),
        .div_dbz  (div_dbz),
        .div_ovf  (div_ovf),
        .div_val  (div_val),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_val  (rsp_val),
        .rsp_tag  (rsp_tag),
        .rsp_err  (rsp_err),
        .count    (count)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [8:0]  tag;
        logic [15:0] val;
        logic [1:0]  err;
    } vec_t;

    typedef struct {
        logic [15:0] val;
        logic [8:0]  tag;
        logic [1:0]  err;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    int   got_tags[$];
    bit   sb_en      = 1'b0;
    int   n_start    = 0;
    bit   prev_stall = 1'b0;
    logic [15:0] pv_val;
    logic [8:0]  pv_tag;
    logic [1:0]  pv_err;

    // Divider stand-in controls
    bit   never_done = 1'b0;
    bit   rand_lat   = 1'b0;
    int   lat_cfg    = 5;
    int   n_done     = 0;

    // Signed fixed-point quotient, truncated toward zero, sign-magnitude overflow rule
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] v, output logic [1:0] e);
        int ua, ub, q;
        ua = a[15] ? 65536 - int'(a) : int'(a);
        ub = b[15] ? 65536 - int'(b) : int'(b);
        if (ub == 0) begin
            v = '0;
            e = 2'b01;
        end else begin
            q = (ua * (1 << FBITS)) / ub;
            if (q >= 32768) begin
                v = '0;
                e = 2'b10;
            end else begin
                v = (a[15] ^ b[15]) ? 16'(-q) : 16'(q);
                e = 2'b00;
            end
        end
    endfunction

    // Divider model: driven on the falling edge, raw junk on the quotient when flagged
    logic [15:0] m_a, m_b, m_v;
    logic [1:0]  m_e;
    bit          m_busy = 1'b0;
    int          m_rem  = 0;
    always @(negedge clk) begin
        div_done = 1'b0;
        if (div_start) begin
            m_busy = 1'b1;
            m_a    = div_a;
            m_b    = div_b;
            m_rem  = rand_lat ? int'($urandom_range(1, 30)) : lat_cfg;
        end else if (m_busy && !never_done) begin
            m_rem = m_rem - 1;
            if (m_rem <= 0) begin
                m_busy = 1'b0;
                ref_div(m_a, m_b, m_v, m_e);
                div_done  = 1'b1;
                div_dbz   = m_e[0];
                div_ovf   = m_e[1];
                div_valid = (m_e == 2'b00);
                div_val   = (m_e != 2'b00) ? 16'hA5A5 : m_v;
                n_done    = n_done + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observes one cycle at the falling edge: scoreboard and stall stability
    task automatic monitor();
        logic [15:0] v;
        logic [1:0]  e;
        exp_t        x;
        if (!rst_n) begin
            prev_stall = 1'b0;
            return;
        end
        if (div_start) n_start++;
        if (sb_en && req_valid && req_ready) begin
            ref_div(req_a, req_b, v, e);
            x.val = v;
            x.tag = req_tag;
            x.err = e;
            exp_q.push_back(x);
        end
        if (prev_stall) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_val", 32'(rsp_val), 32'(pv_val));
            check("stall_tag", 32'(rsp_tag), 32'(pv_tag));
            check("stall_err", 32'(rsp_err), 32'(pv_err));
        end
        if (rsp_valid && rsp_ready) begin
            got_tags.push_back(int'(rsp_tag));
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got response tag %0d, expected none", rsp_tag);
                end else begin
                    x = exp_q.pop_front();
                    check("sb_val", 32'(rsp_val), 32'(x.val));
                    check("sb_tag", 32'(rsp_tag), 32'(x.tag));
                    check("sb_err", 32'(rsp_err), 32'(x.err));
                end
            end
        end
        prev_stall = rsp_valid && !rsp_ready;
        pv_val = rsp_val;
        pv_tag = rsp_tag;
        pv_err = rsp_err;
    endtask

    // Advance one cycle; inputs change only at posedge+1
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [8:0] tag,
                        input int max_wait, output bit ok);
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
    endtask

    task automatic wait_rsp(input int max_wait, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    vec_t vecs[8];
    bit   ok;
    int   k;
    int   acc_n;
    int   start0;
    int   done0;
    bit   saw_rsp;
    bit   saw_start;
    int   sent;
    bit   acc;

    initial begin
        vecs[0] = '{16'h0300, 16'h0200, 9'd5,   16'h0180, 2'b00};
        vecs[1] = '{16'h0100, 16'h0000, 9'd7,   16'h0000, 2'b01};
        vecs[2] = '{16'hFD00, 16'h0200, 9'd8,   16'hFE80, 2'b00};
        vecs[3] = '{16'h8000, 16'h0100, 9'd9,   16'h0000, 2'b10};
        vecs[4] = '{16'h0080, 16'hFF00, 9'd10,  16'hFF80, 2'b00};
        vecs[5] = '{16'h7FFF, 16'h0080, 9'd11,  16'h0000, 2'b10};
        vecs[6] = '{16'hFFFF, 16'h0001, 9'd12,  16'hFF00, 2'b00};
        vecs[7] = '{16'h1234, 16'h7FFF, 9'd511, 16'h0024, 2'b00};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_a", 32'(div_a), 32'd0);
        check("rst_div_b", 32'(div_b), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_val", 32'(rsp_val), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one request at a time
        lat_cfg = 27;
        for (int i = 0; i < 8; i++) begin
            start0 = n_start;
            push(vecs[i].a, vecs[i].b, vecs[i].tag, 10, ok);
            req_valid = 1'b0;
            check($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
            if (i == 0) begin
                k = 0;
                while (!div_start && k < 10) begin
                    step();
                    k++;
                end
                check("latency_start", 32'(k), 32'd2);
            end
            wait_rsp(200, ok);
            check($sformatf("vec%0d_rsp", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_val", i), 32'(rsp_val), 32'(vecs[i].val));
            check($sformatf("vec%0d_tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
            check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
            accept_rsp();
            check($sformatf("vec%0d_starts", i), 32'(n_start - start0), 32'd1);
            check($sformatf("vec%0d_dropped", i), 32'(rsp_valid), 32'd0);
        end

        // Full FIFO and backpressure: six back-to-back requests, response held
        lat_cfg = 5;
        sb_en   = 1'b1;
        got_tags.delete();
        acc_n   = 0;
        for (int t = 1; t <= 6; t++) begin
            push(16'(t * 256), 16'h0200, 9'(t), 40, ok);
            if (ok) acc_n++;
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(acc_n), 32'd5);
        check("bp_count", 32'(count), 32'd4);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_first_tag", 32'(rsp_tag), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 500 && got_tags.size() < 5; i++) step();
        rsp_ready = 1'b0;
        check("bp_rsp_count", 32'(got_tags.size()), 32'd5);
        for (int i = 0; i < got_tags.size(); i++)
            check($sformatf("bp_order%0d", i), 32'(got_tags[i]), 32'(i + 1));
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        // Timeout: divider never answers, next request issues normally
        never_done = 1'b1;
        push(16'h0300, 16'h0200, 9'd20, 10, ok);
        push(16'h0300, 16'h0200, 9'd21, 10, ok);
        req_valid = 1'b0;
        k = 0;
        while (!div_start && k < 10) begin
            step();
            k++;
        end
        check("tmo_start_seen", 32'(div_start), 32'd1);
        k = 0;
        while (!rsp_valid && k < 200) begin
            step();
            k++;
        end
        check("tmo_cycles", 32'(k), 32'(TIMEOUT));
        never_done = 1'b0;
        check("tmo_err", 32'(rsp_err), 32'd3);
        check("tmo_val", 32'(rsp_val), 32'd0);
        check("tmo_tag", 32'(rsp_tag), 32'd20);
        accept_rsp();
        wait_rsp(200, ok);
        check("tmo_next_rsp", 32'(ok), 32'd1);
        check("tmo_next_tag", 32'(rsp_tag), 32'd21);
        check("tmo_next_err", 32'(rsp_err), 32'd0);
        check("tmo_next_val", 32'(rsp_val), 32'h0180);
        accept_rsp();

        // Reset during WAIT with two requests queued
        lat_cfg = 30;
        push(16'h0300, 16'h0200, 9'd30, 10, ok);
        push(16'h0300, 16'h0200, 9'd31, 10, ok);
        push(16'h0300, 16'h0200, 9'd32, 10, ok);
        req_valid = 1'b0;
        step();
        check("mid_count", 32'(count), 32'd2);
        done0 = n_done;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_div_start", 32'(div_start), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        saw_rsp   = 1'b0;
        saw_start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            saw_rsp   = saw_rsp | rsp_valid;
            saw_start = saw_start | div_start;
            step();
        end
        rsp_ready = 1'b0;
        check("mid_late_done", 32'(n_done - done0), 32'd1);
        check("mid_no_rsp", 32'(saw_rsp), 32'd0);
        check("mid_no_start", 32'(saw_start), 32'd0);

        // Randomized traffic against the scoreboard
        sb_en    = 1'b1;
        rand_lat = 1'b1;
        sent     = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            acc = req_valid && req_ready;
            step();
            if (acc) begin
                sent++;
                req_valid = 1'b0;
            end
            if (!req_valid && sent < NRAND && ($urandom % 3 != 0)) begin
                req_a = 16'($urandom);
                case ($urandom % 6)
                    0:       req_b = 16'h0000;
                    1:       req_b = 16'($urandom_range(1, 255));
                    2:       req_b = 16'h0100;
                    default: req_b = 16'($urandom);
                endcase
                req_tag   = 9'($urandom);
                req_valid = 1'b1;
            end
            rsp_ready = ($urandom % 4 != 0);
            if (sent == NRAND && exp_q.size() == 0) break;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rand_sent", 32'(sent), 32'(NRAND));
        check("rand_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
